// File: rtl/hazard_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctl
//  Purpose  : Pipeline interlock controller for the mips789 core. Detects
//             load-use hazards and mfhi/mflo reads while the mul/div unit is
//             busy, holds PC/IF-ID/forwarding rn registers (pause) and
//             injects bubbles into ID/EX (id_bubble). A three-state FSM
//             sequences mul/div waits with a timeout abort.
//  Ports    : clk, rst (async, active-high)
//             id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_rd : ID-stage info
//             ex_is_load, ex_we, ex_wr_rn                      : EX-stage info
//             md_busy, flush                                   : control in
//             pause, id_bubble   : Mealy interlock outputs
//             state_o            : current FSM state
//             md_err             : sticky mul/div timeout flag
//             stall_cnt          : stall cycle counter (CNT_W bits)
//  Options  : HAZ_PERF_CNT_EN - when defined, stall_cnt counts pause cycles
//             and saturates; otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_rd,
  input  logic             ex_is_load,
  input  logic             ex_we,
  input  logic [4:0]       ex_wr_rn,
  input  logic             md_busy,
  input  logic             flush,
  output logic             pause,
  output logic             id_bubble,
  output logic [1:0]       state_o,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TO_LAST = TW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_WAIT = 2'd1,
    S_MD_RES  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            md_err_q;
  logic            w_set_err;
  logic            w_ld_haz;
  logic            w_md_haz;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_ld_haz = ex_is_load && ex_we && (ex_wr_rn != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_wr_rn)) ||
                     (id_uses_rt && (id_rt == ex_wr_rn)));
  assign w_md_haz = id_md_rd && md_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      to_cnt_q <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (w_set_err) begin
        md_err_q <= 1'b1;
      end
    end
  end

  // Priority everywhere: flush, then mul/div sequencing, then load-use.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    w_set_err = 1'b0;
    pause     = 1'b0;
    id_bubble = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          id_bubble = 1'b1;
        end else if (w_md_haz) begin
          pause     = 1'b1;
          id_bubble = 1'b1;
          state_d   = S_MD_WAIT;
          to_cnt_d  = '0;
        end else if (w_ld_haz) begin
          // One bubble suffices: next cycle EX holds it and MEM forwards.
          pause     = 1'b1;
          id_bubble = 1'b1;
        end
      end
      S_MD_WAIT: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (flush) begin
          id_bubble = 1'b1;
          state_d   = S_RUN;
        end else begin
          pause     = 1'b1;
          id_bubble = 1'b1;
          if (!md_busy) begin
            state_d = S_MD_RES;
          end else if (to_cnt_q == C_TO_LAST) begin
            w_set_err = 1'b1;
            state_d   = S_RUN;
          end
        end
      end
      S_MD_RES: begin
        // Extra cycle lets the hi/lo write land before mfhi/mflo issues.
        state_d = S_RUN;
        if (flush) begin
          id_bubble = 1'b1;
        end else begin
          pause     = 1'b1;
          id_bubble = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    if (rst) begin
      pause     = 1'b0;
      id_bubble = 1'b0;
    end
  end

  assign state_o = state_q;
  assign md_err  = md_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pause && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
